div_axis_core: RTL and testbench



---
 rtl/div_pkg.sv | 19 +
 rtl/div_axis_core_step.sv | 21 ++
 rtl/div_axis_core.sv | 178 +++++++++++++++++
 tb/tb_div_axis_core.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Optional build macro used by the core: DIV_EARLY_OUT_EN.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  localparam int DIV_W = 32;

  // Field offsets in the packed result {quotient, remainder}
  localparam int Q_LSB = DIV_W;
  localparam int R_LSB = 0;

  localparam logic [DIV_W-1:0] DIV0_Q = '1;

endpackage

// File: rtl/div_axis_core_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor magnitude.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diffLo;

  assign shifted = {rem_i, bit_i};
  // Only the low bits of the difference are kept: when the trial succeeds the result fits in WIDTH bits
  assign diffLo  = shifted[WIDTH-1:0] - dvsr_i;
  assign q_bit_o = (shifted >= {1'b0, dvsr_i});
  assign rem_o   = q_bit_o ? diffLo : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_axis_core.sv
// AXI-Stream iterative restoring divider (IDLE -> CALC -> FIX), result = {quotient, remainder}.
// Build macro DIV_EARLY_OUT_EN skips CALC for divide-by-zero or |dividend| < |divisor|.
module div_axis_core
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_W,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int QOFF  = (WIDTH == DIV_W) ? Q_LSB : (R_LSB + WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] magOf(input logic [WIDTH-1:0] v);
    return (SIGNED && v[WIDTH-1]) ? -v : v;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               haveDvd_q, haveDvd_d, haveDvs_q, haveDvs_d;
  logic               dvdRdy_q, dvdRdy_d, dvsRdy_q, dvsRdy_d;
  logic [WIDTH-1:0]   dvdRaw_q, dvdRaw_d, dvsRaw_q, dvsRaw_d;
  logic [WIDTH-1:0]   dvsMag_q, dvsMag_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic               negQ_q, negQ_d, negR_q, negR_d, div0_q, div0_d;
  logic               outValid_q, outValid_d;
  logic [2*WIDTH-1:0] outData_q, outData_d;

  logic [WIDTH-1:0]   stepRem, qFix, rFix;
  logic               stepQ, dvdFire, dvsFire;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .bit_i   (quo_q[WIDTH-1]),
    .dvsr_i  (dvsMag_q),
    .rem_o   (stepRem),
    .q_bit_o (stepQ)
  );

  assign dvdFire = s_axis_dividend_tvalid && dvdRdy_q;
  assign dvsFire = s_axis_divisor_tvalid && dvsRdy_q;
  assign qFix    = negQ_q ? -quo_q : quo_q;
  assign rFix    = negR_q ? -rem_q : rem_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    haveDvd_d  = haveDvd_q;
    haveDvs_d  = haveDvs_q;
    dvdRaw_d   = dvdRaw_q;
    dvsRaw_d   = dvsRaw_q;
    dvsMag_d   = dvsMag_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    negQ_d     = negQ_q;
    negR_d     = negR_q;
    div0_d     = div0_q;
    outValid_d = 1'b0;
    outData_d  = outData_q;

    case (state_q)
      IDLE: begin
        if (dvdFire) begin
          haveDvd_d = 1'b1;
          dvdRaw_d  = s_axis_dividend_tdata;
        end
        if (dvsFire) begin
          haveDvs_d = 1'b1;
          dvsRaw_d  = s_axis_divisor_tdata;
        end
        // Second operand captured on this edge: load magnitudes and remember the signs
        if (haveDvd_d && haveDvs_d) begin
          state_d   = CALC;
          cnt_d     = CNT_TOP;
          rem_d     = '0;
          quo_d     = magOf(dvdRaw_d);
          dvsMag_d  = magOf(dvsRaw_d);
          negQ_d    = SIGNED && (dvdRaw_d[WIDTH-1] ^ dvsRaw_d[WIDTH-1]);
          negR_d    = SIGNED && dvdRaw_d[WIDTH-1];
          div0_d    = (dvsRaw_d == '0);
          haveDvd_d = 1'b0;
          haveDvs_d = 1'b0;
        end
      end
      CALC: begin
`ifdef DIV_EARLY_OUT_EN
        if ((cnt_q == CNT_TOP) && (div0_q || (quo_q < dvsMag_q))) begin
          state_d = FIX;
          rem_d   = quo_q;
          quo_d   = '0;
        end else begin
          rem_d = stepRem;
          quo_d = {quo_q[WIDTH-2:0], stepQ};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = FIX;
        end
`else
        rem_d = stepRem;
        quo_d = {quo_q[WIDTH-2:0], stepQ};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
`endif
      end
      FIX: begin
        state_d    = IDLE;
        outValid_d = 1'b1;
        outData_d  = '0;
        // Divide by zero reports the raw dividend and an unnegated all-ones quotient
        if (div0_q) begin
          outData_d[QOFF +: WIDTH]  = {WIDTH{DIV0_Q[0]}};
          outData_d[R_LSB +: WIDTH] = dvdRaw_q;
        end else begin
          outData_d[QOFF +: WIDTH]  = qFix;
          outData_d[R_LSB +: WIDTH] = rFix;
        end
      end
      default: state_d = IDLE;
    endcase

    dvdRdy_d = (state_d == IDLE) && !haveDvd_d;
    dvsRdy_d = (state_d == IDLE) && !haveDvs_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      haveDvd_q  <= 1'b0;
      haveDvs_q  <= 1'b0;
      dvdRdy_q   <= 1'b0;
      dvsRdy_q   <= 1'b0;
      dvdRaw_q   <= '0;
      dvsRaw_q   <= '0;
      dvsMag_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      negQ_q     <= 1'b0;
      negR_q     <= 1'b0;
      div0_q     <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      haveDvd_q  <= haveDvd_d;
      haveDvs_q  <= haveDvs_d;
      dvdRdy_q   <= dvdRdy_d;
      dvsRdy_q   <= dvsRdy_d;
      dvdRaw_q   <= dvdRaw_d;
      dvsRaw_q   <= dvsRaw_d;
      dvsMag_q   <= dvsMag_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      negQ_q     <= negQ_d;
      negR_q     <= negR_d;
      div0_q     <= div0_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

  assign s_axis_dividend_tready = dvdRdy_q;
  assign s_axis_divisor_tready  = dvsRdy_q;
  assign m_axis_dout_tvalid     = outValid_q;
  assign m_axis_dout_tdata      = outData_q;

endmodule

// File: tb/tb_div_axis_core.sv
// Directed bench for div_axis_core: instance 0 is SIGNED=1, instance 1 is SIGNED=0.
// Latency is counted in edges including the handshake edge T (34 full, 3 early-out).
module tb_div_axis_core;
  import div_pkg::*;

  logic        clk, rst;
  logic        dvdV[2], dvsV[2], dvdR[2], dvsR[2], tv[2];
  logic [31:0] dvdD[2], dvsD[2];
  logic [63:0] td[2];
  int total, bad;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 3;
`else
  localparam int EARLY_LAT = 34;
`endif

  div_axis_core #(.WIDTH(32), .SIGNED(1'b1)) dutS (
    .clk(clk), .rst(rst),
    .s_axis_dividend_tvalid(dvdV[0]), .s_axis_dividend_tready(dvdR[0]), .s_axis_dividend_tdata(dvdD[0]),
    .s_axis_divisor_tvalid(dvsV[0]),  .s_axis_divisor_tready(dvsR[0]),  .s_axis_divisor_tdata(dvsD[0]),
    .m_axis_dout_tvalid(tv[0]), .m_axis_dout_tdata(td[0])
  );

  div_axis_core #(.WIDTH(32), .SIGNED(1'b0)) dutU (
    .clk(clk), .rst(rst),
    .s_axis_dividend_tvalid(dvdV[1]), .s_axis_dividend_tready(dvdR[1]), .s_axis_dividend_tdata(dvdD[1]),
    .s_axis_divisor_tvalid(dvsV[1]),  .s_axis_divisor_tready(dvsR[1]),  .s_axis_divisor_tdata(dvsD[1]),
    .m_axis_dout_tvalid(tv[1]), .m_axis_dout_tdata(td[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation; returns at edge T + 1 time unit. gap = cycles between dividend and divisor.
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b, input int gap);
    @(negedge clk);
    dvdV[d] = 1'b1;
    dvdD[d] = a;
    if (gap == 0) begin
      dvsV[d] = 1'b1;
      dvsD[d] = b;
    end
    for (int k = 0; k < 100 && !(dvdR[d] && (gap != 0 || dvsR[d])); k++) @(negedge clk);
    @(posedge clk);
    #1;
    dvdV[d] = 1'b0;
    dvsV[d] = 1'b0;
    if (gap != 0) begin
      repeat (gap) @(negedge clk);
      dvsV[d] = 1'b1;
      dvsD[d] = b;
      for (int k = 0; k < 100 && !dvsR[d]; k++) @(negedge clk);
      @(posedge clk);
      #1;
      dvsV[d] = 1'b0;
    end
  endtask

  task automatic waitResult(input int d, output int lat, output logic [63:0] res);
    lat = -1;
    res = 'x;
    for (int n = 2; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (tv[d]) begin
        lat = n;
        res = td[d];
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++; if (dvdR[d] !== 1'b0) begin bad++; $display("[TB] FAIL rst_dvd_ready dut%0d got %b want 0", d, dvdR[d]); end
      total++; if (dvsR[d] !== 1'b0) begin bad++; $display("[TB] FAIL rst_dvs_ready dut%0d got %b want 0", d, dvsR[d]); end
      total++; if (tv[d] !== 1'b0) begin bad++; $display("[TB] FAIL rst_tvalid dut%0d got %b want 0", d, tv[d]); end
      total++; if (td[d] !== 64'h0) begin bad++; $display("[TB] FAIL rst_tdata dut%0d got %h want 0", d, td[d]); end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if ({dvdR[0], dvsR[0], dvdR[1], dvsR[1]} !== 4'b1111) begin
      bad++; $display("[TB] FAIL ready_after_rst got %b want 1111", {dvdR[0], dvsR[0], dvdR[1], dvsR[1]});
    end
  endtask

  task automatic test_basic;
    int lat;
    logic [63:0] res;
    issue(0, 32'd100, 32'd7, 0);
    waitResult(0, lat, res);
    total++; if (lat !== 34) begin bad++; $display("[TB] FAIL basic_latency got %0d want 34", lat); end
    total++; if (res[Q_LSB +: 32] !== 32'h0000000E) begin bad++; $display("[TB] FAIL basic_q got %h want 0000000e", res[Q_LSB +: 32]); end
    total++; if (res[R_LSB +: 32] !== 32'h00000002) begin bad++; $display("[TB] FAIL basic_r got %h want 00000002", res[R_LSB +: 32]); end
    @(posedge clk);
    #1;
    total++; if (tv[0] !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse_width got %b want 0", tv[0]); end
    total++; if (td[0] !== 64'h0000000E_00000002) begin bad++; $display("[TB] FAIL basic_hold got %h want 0000000e00000002", td[0]); end
  endtask

  task automatic test_signed;
    int lat;
    logic [63:0] res;
    issue(0, 32'hFFFFFFF9, 32'd2, 5);
    waitResult(0, lat, res);
    total++; if (lat !== 34) begin bad++; $display("[TB] FAIL gap_latency got %0d want 34", lat); end
    total++; if (res !== 64'hFFFFFFFD_FFFFFFFF) begin bad++; $display("[TB] FAIL neg7_div2 got %h want fffffffdffffffff", res); end
    issue(0, 32'hFFFFFF9C, 32'd7, 0);
    waitResult(0, lat, res);
    total++; if (res !== 64'hFFFFFFF2_FFFFFFFE) begin bad++; $display("[TB] FAIL neg100_div7 got %h want fffffff2fffffffe", res); end
    issue(0, 32'd100, 32'hFFFFFFF9, 0);
    waitResult(0, lat, res);
    total++; if (res !== 64'hFFFFFFF2_00000002) begin bad++; $display("[TB] FAIL 100_divneg7 got %h want fffffff200000002", res); end
    issue(0, 32'd3, 32'hFFFFFFF6, 0);
    waitResult(0, lat, res);
    total++; if (lat !== EARLY_LAT) begin bad++; $display("[TB] FAIL small_latency got %0d want %0d", lat, EARLY_LAT); end
    total++; if (res !== 64'h00000000_00000003) begin bad++; $display("[TB] FAIL 3_divneg10 got %h want 0000000000000003", res); end
  endtask

  task automatic test_overflow;
    int lat;
    logic [63:0] res;
    issue(0, 32'h80000000, 32'hFFFFFFFF, 0);
    waitResult(0, lat, res);
    total++; if (res !== 64'h80000000_00000000) begin bad++; $display("[TB] FAIL overflow got %h want 8000000000000000", res); end
    total++; if ($isunknown({tv[0], td[0]}) !== 1'b0) begin bad++; $display("[TB] FAIL overflow_x got %h want known", td[0]); end
  endtask

  task automatic test_div0;
    int lat;
    logic [63:0] res;
    issue(1, 32'hFFFFFFFF, 32'd0, 0);
    waitResult(1, lat, res);
    total++; if (lat !== EARLY_LAT) begin bad++; $display("[TB] FAIL div0_latency got %0d want %0d", lat, EARLY_LAT); end
    total++; if (res !== 64'hFFFFFFFF_FFFFFFFF) begin bad++; $display("[TB] FAIL div0_unsigned got %h want ffffffffffffffff", res); end
    issue(0, 32'hFFFFFFFB, 32'd0, 0);
    waitResult(0, lat, res);
    total++; if (res !== 64'hFFFFFFFF_FFFFFFFB) begin bad++; $display("[TB] FAIL div0_signed got %h want fffffffffffffffb", res); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    logic [63:0] res1, res2;
    time t1, t2;
    issue(1, 32'h80000000, 32'd3, 0);
    waitResult(1, lat1, res1);
    t1 = $time;
    issue(1, 32'd100, 32'd7, 0);
    waitResult(1, lat2, res2);
    t2 = $time;
    total++; if (res1 !== 64'h2AAAAAAA_00000002) begin bad++; $display("[TB] FAIL b2b_first got %h want 2aaaaaaa00000002", res1); end
    total++; if (res2 !== 64'h0000000E_00000002) begin bad++; $display("[TB] FAIL b2b_second got %h want 0000000e00000002", res2); end
    total++; if ((t2 - t1) !== 64'd340) begin bad++; $display("[TB] FAIL b2b_spacing got %0t want 340", t2 - t1); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    logic [63:0] res;
    issue(0, 32'd1000, 32'd3, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (td[0] !== 64'h0) begin bad++; $display("[TB] FAIL midrst_tdata got %h want 0", td[0]); end
    total++; if ({tv[0], dvdR[0], dvsR[0]} !== 3'b000) begin bad++; $display("[TB] FAIL midrst_ctrl got %b want 000", {tv[0], dvdR[0], dvsR[0]}); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (tv[0]) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL midrst_no_pulse got %0d pulses want 0", seen); end
    issue(0, 32'd9, 32'd3, 0);
    waitResult(0, lat, res);
    total++; if (res !== 64'h00000003_00000000) begin bad++; $display("[TB] FAIL after_rst_op got %h want 0000000300000000", res); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int d = 0; d < 2; d++) begin
      dvdV[d] = 1'b0;
      dvsV[d] = 1'b0;
      dvdD[d] = '0;
      dvsD[d] = '0;
    end
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_div0();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
